// File: rtl/mux_4to1_64bit_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_4to1_64bit_rr_arb
//
// Round-robin arbiter that shares one 4-to-1 WIDTH-bit mux between four
// valid/ready requesters. Each cycle it picks one winner, drives the mux
// select, and registers the winning word into a single output stage that
// has its own valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid[i]  requester i has a word
//   in_ready[i]  requester i's word is taken this cycle (one-hot or zero)
//   data0..3     requester payloads
//   out_valid    output stage holds a word
//   out_ready    downstream accepts the word
//   out_data     registered selected word
//   out_id       index of the requester that supplied out_data
//   sel          combinational mux select (current winner, ptr when idle)
//   grant_cnt0..3 saturating count of accepted words per requester
// ---------------------------------------------------------------------------
module mux_4to1_64bit_rr_arb #(
  parameter int WIDTH     = 64,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  input  logic [WIDTH-1:0]     data0,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     data3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_id,
  output logic [SEL_WIDTH-1:0] sel,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1,
  output logic [15:0]          grant_cnt2,
  output logic [15:0]          grant_cnt3
);

  localparam int NREQ = 4;

  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] winner;
  logic                 accept_en;
  logic                 accept;
  logic [WIDTH-1:0]     data_mux;
  logic [15:0]          grant_cnt [NREQ];

  // Search ptr+3 down to ptr+0 so the last hit is the requester closest to
  // ptr in round-robin order. With nothing valid the winner stays at ptr.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    winner = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (in_valid[ptr + SEL_WIDTH'(k)]) winner = ptr + SEL_WIDTH'(k);
    end
  end

  assign sel = winner;

  // The output stage can take a word when empty or when it drains this cycle.
  assign accept_en = !out_valid || out_ready;
  assign accept    = !rst && accept_en && (|in_valid);
  assign in_ready  = accept ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    data_mux = data3;
    case (sel)
      2'd0:    data_mux = data0;
      2'd1:    data_mux = data1;
      2'd2:    data_mux = data2;
      default: data_mux = data3;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
      // NOTE: the counter array is small flop storage whose cleared state is
      // visible on ports, so it is reset explicitly rather than left as RAM.
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_mux;
        out_id    <= winner;
        ptr       <= winner + SEL_WIDTH'(1);
        if (grant_cnt[winner] != 16'hFFFF)
          grant_cnt[winner] <= grant_cnt[winner] + 16'd1;
      end else if (out_ready) begin
        // Draining with no replacement: data and id keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

  assign grant_cnt0 = grant_cnt[0];
  assign grant_cnt1 = grant_cnt[1];
  assign grant_cnt2 = grant_cnt[2];
  assign grant_cnt3 = grant_cnt[3];

endmodule

// File: tb/tb_mux_4to1_64bit_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1_64bit_rr_arb
//
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural round-robin model held in plain integers.
// ---------------------------------------------------------------------------
module tb_mux_4to1_64bit_rr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] data_in [4];
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_id;
  logic [1:0]  sel;
  logic [15:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  logic [63:0] m_data;
  int          m_id;
  int          m_cnt [4];

  always #5 clk = ~clk;

  mux_4to1_64bit_rr_arb #(.WIDTH(64), .SEL_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data0      (data_in[0]),
    .data1      (data_in[1]),
    .data2      (data_in[2]),
    .data3      (data_in[3]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .sel        (sel),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2),
    .grant_cnt3 (grant_cnt3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Called at a falling edge with inputs already driven:
  // checks all outputs against the model, then advances the model at the
  // rising edge and returns at the next falling edge.
  task automatic cycle();
    int   win;
    bit   acc;
    logic [3:0] exp_ready;
    int   exp_sel;
    #1;
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && in_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    exp_sel   = (win < 0) ? m_ptr : win;
    acc       = !rst && (!m_valid || out_ready) && (win >= 0);
    exp_ready = acc ? (4'b0001 << win) : 4'b0000;

    check("sel",        64'(sel),        64'(exp_sel));
    check("in_ready",   64'(in_ready),   64'(exp_ready));
    check("out_valid",  64'(out_valid),  64'(m_valid));
    check("out_data",   out_data,        m_data);
    check("out_id",     64'(out_id),     64'(m_id));
    check("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt[0]));
    check("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt[1]));
    check("grant_cnt2", 64'(grant_cnt2), 64'(m_cnt[2]));
    check("grant_cnt3", 64'(grant_cnt3), 64'(m_cnt[3]));

    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_data  = data_in[win];
      m_id    = win;
      m_ptr   = (win + 1) % 4;
      if (m_cnt[win] < 65535) m_cnt[win]++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy, input int n);
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data_in[i] = '0;
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(negedge clk);

    // Reset then idle
    drive(4'h0, 1'b0, 2);
    rst = 1'b0;
    drive(4'h0, 1'b1, 5);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Full contention: rotate 0,1,2,3 twice
    for (int i = 0; i < 4; i++) data_in[i] = 64'h1111_0000_0000_0000 | 64'(i);
    drive(4'hF, 1'b1, 8);
    check("fc_cnt0", 64'(grant_cnt0), 64'd2);
    check("fc_cnt1", 64'(grant_cnt1), 64'd2);
    check("fc_cnt2", 64'(grant_cnt2), 64'd2);
    check("fc_cnt3", 64'(grant_cnt3), 64'd2);
    check("fc_last_id", 64'(out_id), 64'd3);

    // Backpressure: empty the stage, accept requester 0, then stall
    drive(4'h0, 1'b1, 1);
    drive(4'b0101, 1'b1, 1);
    drive(4'b0101, 1'b0, 3);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_id",    64'(out_id),    64'd0);
    drive(4'b0101, 1'b1, 1);
    check("bp_next_id2",   64'(out_id),    64'd2);
    drive(4'b0101, 1'b1, 1);
    check("bp_next_id0",   64'(out_id),    64'd0);

    // Pointer skip/wrap: grant 2 (ptr=3), then only 1, then {3,0} from ptr 2
    drive(4'b0100, 1'b1, 1);
    drive(4'b0010, 1'b1, 1);
    check("wrap_id1", 64'(out_id), 64'd1);
    drive(4'b1001, 1'b1, 1);
    check("wrap_id3", 64'(out_id), 64'd3);

    // Drain and bubble
    data_in[1] = 64'hDEAD_BEEF_CAFE_F00D;
    drive(4'b0010, 1'b1, 1);
    check("bubble_valid", 64'(out_valid), 64'd1);
    check("bubble_data",  out_data, 64'hDEAD_BEEF_CAFE_F00D);
    drive(4'b0000, 1'b1, 1);
    check("bubble_gone",  64'(out_valid), 64'd0);
    drive(4'b0000, 1'b1, 2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) data_in[i] = {$urandom, $urandom};
      drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1);
    end
    rst = 1'b0;

    // Saturation: 65535 accepts of requester 0 from a fresh reset
    rst = 1'b1;
    drive(4'h0, 1'b1, 1);
    rst = 1'b0;
    data_in[0] = 64'h0123_4567_89AB_CDEF;
    drive(4'b0001, 1'b1, 65535);
    check("sat_cnt0_max",  64'(grant_cnt0), 64'hFFFF);
    drive(4'b0001, 1'b1, 1);
    check("sat_cnt0_hold", 64'(grant_cnt0), 64'hFFFF);
    check("sat_valid",     64'(out_valid), 64'd1);

    // Reset mid-transfer drops the held word
    rst = 1'b1;
    drive(4'b0001, 1'b0, 1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cnt0",      64'(grant_cnt0), 64'd0);
    check("rst_cnt_rest",  64'(grant_cnt1 | grant_cnt2 | grant_cnt3), 64'd0);
    rst = 1'b0;
    drive(4'b0000, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
